// File: rtl/alu_pkg.sv
// +----------------------------------------------------------------------+
// | alu_pkg : opcodes, FSM state encoding and width default for alu_iter |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package alu_pkg;

  localparam int WIDTH_DEFAULT = 32;

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_NOTA  = 4'd2;
  localparam logic [3:0] OP_AND   = 4'd3;
  localparam logic [3:0] OP_OR    = 4'd4;
  localparam logic [3:0] OP_XOR   = 4'd5;
  localparam logic [3:0] OP_SLT   = 4'd6;
  localparam logic [3:0] OP_EQU   = 4'd7;
  localparam logic [3:0] OP_SLL   = 4'd8;
  localparam logic [3:0] OP_SLTU  = 4'd9;
  localparam logic [3:0] OP_SRL   = 4'd10;
  localparam logic [3:0] OP_SRA   = 4'd11;
  localparam logic [3:0] OP_MUL   = 4'd12;
  localparam logic [3:0] OP_MULHU = 4'd13;
  localparam logic [3:0] OP_DIVU  = 4'd14;
  localparam logic [3:0] OP_REMU  = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_ITER = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Opcodes 12-15 share the 2'b11 prefix; 14/15 are the divide pair.
  function automatic logic is_md_op(input logic [3:0] op);
    return op[3] & op[2];
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    return op[3] & op[2] & op[1];
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_iter_muldiv.sv
// +----------------------------------------------------------------------+
// | alu_iter_muldiv : WIDTH-step shift-add multiply / restoring divide   |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module alu_iter_muldiv #(
  parameter int WIDTH = 32,
  parameter int CW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] prod_lo,
  output logic [WIDTH-1:0] prod_hi,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem
);

  logic             busy;
  logic [CW-1:0]    cnt;
  logic             div_mode;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] opd;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH+1:0] div_diff;
  logic             div_fits;
  logic [WIDTH-1:0] hi_next;
  logic [WIDTH-1:0] lo_next;
  logic             unused_diff_bit;

  // hi:lo is the running product (multiply) or remainder:quotient (divide).
  assign mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, opd} : {(WIDTH+1){1'b0}});
  assign div_diff = {1'b0, hi, lo[WIDTH-1]} - {2'b00, opd};
  assign div_fits = ~div_diff[WIDTH+1];
  assign unused_diff_bit = div_diff[WIDTH];

  always_comb begin
    hi_next = mul_sum[WIDTH:1];
    lo_next = {mul_sum[0], lo[WIDTH-1:1]};
    if (div_mode) begin
      hi_next = div_fits ? div_diff[WIDTH-1:0] : {hi[WIDTH-2:0], lo[WIDTH-1]};
      lo_next = {lo[WIDTH-2:0], div_fits};
    end
  end

  // Outputs present the final-step values so the caller can latch them on done.
  assign done    = busy && (cnt == '0);
  assign prod_lo = lo_next;
  assign prod_hi = hi_next;
  assign quot    = lo_next;
  assign rem     = hi_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy     <= 1'b0;
      cnt      <= '0;
      div_mode <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      opd      <= '0;
    end else if (start) begin
      busy     <= 1'b1;
      cnt      <= CW'(WIDTH - 1);
      div_mode <= is_div;
      hi       <= '0;
      lo       <= a;
      opd      <= b;
    end else if (busy) begin
      hi <= hi_next;
      lo <= lo_next;
      if (cnt == '0) begin
        busy <= 1'b0;
      end else begin
        cnt <= cnt - 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/alu_iter.sv
// +----------------------------------------------------------------------+
// | alu_iter : handshaked ALU, single-cycle ops plus iterative mul/div   |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module alu_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [3:0]       op_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             cout,
  output logic             overflow,
  output logic             div_by_zero
);

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [3:0]       op_q;

  logic             accept;
  logic             iter_start;

  logic             md_done;
  logic [WIDTH-1:0] md_prod_lo;
  logic [WIDTH-1:0] md_prod_hi;
  logic [WIDTH-1:0] md_quot;
  logic [WIDTH-1:0] md_rem;
  logic [WIDTH-1:0] md_res;

  logic             sub_sel;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;
  logic             add_ovf;
  logic             lt_signed;
  logic             lt_unsigned;
  logic             eq;
  logic [SHW-1:0]   shamt;

  logic [WIDTH-1:0] exec_res;
  logic             exec_cout;
  logic             exec_ovf;
  logic             exec_dbz;

  assign in_ready = (state == ST_IDLE) && !rst;
  assign accept   = in_valid && in_ready;

  // Divide by zero bypasses iteration and is resolved in EXEC.
  assign iter_start = accept && is_md_op(op_in) && !(is_div_op(op_in) && (b_in == '0));

  alu_iter_muldiv #(
    .WIDTH (WIDTH)
  ) u_muldiv (
    .clk     (clk),
    .rst     (rst),
    .start   (iter_start),
    .is_div  (op_in[1]),
    .a       (a_in),
    .b       (b_in),
    .done    (md_done),
    .prod_lo (md_prod_lo),
    .prod_hi (md_prod_hi),
    .quot    (md_quot),
    .rem     (md_rem)
  );

  always_comb begin
    case (op_q[1:0])
      2'd0:    md_res = md_prod_lo;
      2'd1:    md_res = md_prod_hi;
      2'd2:    md_res = md_quot;
      default: md_res = md_rem;
    endcase
  end

  // One WIDTH+1 adder; every compare op runs it as a - b.
  assign sub_sel     = (op_q != OP_ADD);
  assign b_eff       = sub_sel ? ~b_q : b_q;
  assign sum         = {1'b0, a_q} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub_sel};
  assign add_ovf     = (a_q[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
  assign lt_signed   = sum[WIDTH-1] ^ add_ovf;
  assign lt_unsigned = ~sum[WIDTH];
  assign eq          = (sum[WIDTH-1:0] == '0);
  assign shamt       = b_q[SHW-1:0];

  always_comb begin
    exec_res  = '0;
    exec_cout = 1'b0;
    exec_ovf  = 1'b0;
    exec_dbz  = 1'b0;
    case (op_q)
      OP_ADD, OP_SUB: begin
        exec_res  = sum[WIDTH-1:0];
        exec_cout = sum[WIDTH];
        exec_ovf  = add_ovf;
      end
      OP_NOTA: exec_res = ~a_q;
      OP_AND:  exec_res = a_q & b_q;
      OP_OR:   exec_res = a_q | b_q;
      OP_XOR:  exec_res = a_q ^ b_q;
      OP_SLT:  exec_res = {{(WIDTH-1){1'b0}}, lt_signed};
      OP_EQU:  exec_res = {{(WIDTH-1){1'b0}}, eq};
      OP_SLL:  exec_res = a_q << shamt;
      OP_SLTU: exec_res = {{(WIDTH-1){1'b0}}, lt_unsigned};
      OP_SRL:  exec_res = a_q >> shamt;
      OP_SRA:  exec_res = $signed(a_q) >>> shamt;
      OP_DIVU: begin
        exec_res = '1;
        exec_dbz = 1'b1;
      end
      OP_REMU: begin
        exec_res = a_q;
        exec_dbz = 1'b1;
      end
      default: exec_res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      out_valid   <= 1'b0;
      result      <= '0;
      zero        <= 1'b0;
      cout        <= 1'b0;
      overflow    <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            a_q   <= a_in;
            b_q   <= b_in;
            op_q  <= op_in;
            state <= iter_start ? ST_ITER : ST_EXEC;
          end
        end
        ST_EXEC: begin
          result      <= exec_res;
          zero        <= (exec_res == '0);
          cout        <= exec_cout;
          overflow    <= exec_ovf;
          div_by_zero <= exec_dbz;
          out_valid   <= 1'b1;
          state       <= ST_DONE;
        end
        ST_ITER: begin
          if (md_done) begin
            result      <= md_res;
            zero        <= (md_res == '0);
            cout        <= 1'b0;
            overflow    <= 1'b0;
            div_by_zero <= 1'b0;
            out_valid   <= 1'b1;
            state       <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/alu_iter.md
ALU_ITER -- requirements
Module: alu_iter

Interface
REQ-001 Parameter WIDTH, default 32, datapath width in bits; SHALL be a power of two, 8 to 64.
REQ-002 Parameter SHW, default $clog2(WIDTH), shift-amount width; SHALL NOT be overridden.
REQ-003 clk  input  1  clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  operand/opcode offer.
REQ-006 in_ready  output  1  block accepts an operation; high only in IDLE.
REQ-007 a_in, b_in  input  WIDTH  operands.
REQ-008 op_in  input  4  opcode: 0 ADD, 1 SUB, 2 NOTA, 3 AND, 4 OR, 5 XOR, 6 SLT, 7 EQU, 8 SLL, 9 SLTU, 10 SRL, 11 SRA, 12 MUL (low half), 13 MULHU, 14 DIVU, 15 REMU.
REQ-009 out_valid  output  1  result and flags valid.
REQ-010 out_ready  input  1  consumer takes the result.
REQ-011 result  output  WIDTH  operation result.
REQ-012 zero, cout, overflow, div_by_zero  output  1 each  status flags.

Function
REQ-013 Transfer in: accept when in_valid and in_ready on the same edge; operands and opcode SHALL be registered on that edge.
REQ-014 FSM states: IDLE, EXEC, ITER, DONE; IDLE->EXEC on accept of ops 0-11, IDLE->ITER on accept of ops 12-15 with b nonzero, IDLE->EXEC on DIVU/REMU with b zero.
REQ-015 EXEC SHALL compute the result in one cycle and go to DONE; out_valid asserts the cycle after EXEC (2 cycles after accept).
REQ-016 ITER SHALL run exactly WIDTH iterations (shift-add multiply, restoring divide), counter WIDTH-1 down to 0, then go to DONE; out_valid asserts WIDTH+1 cycles after accept.
REQ-017 DONE holds out_valid and result/flags stable until out_ready; DONE->IDLE on out_valid and out_ready; in_ready rises the following cycle.
REQ-018 ADD/SUB: computed at WIDTH+1 bits; cout = bit WIDTH (for SUB, 1 = no borrow, i.e. a >= b unsigned); overflow = signed two's-complement overflow.
REQ-019 SLT = 1 iff a < b signed, including overflow cases; SLTU = 1 iff a < b unsigned; EQU = 1 iff a == b; results zero-extended to WIDTH.
REQ-020 SLL/SRL/SRA shift by b[SHW-1:0] only; SRA sign-fills from a[WIDTH-1].
REQ-021 MUL returns low WIDTH bits of unsigned product, MULHU the high WIDTH bits.
REQ-022 DIVU/REMU with b == 0: quotient all ones, remainder = a, div_by_zero = 1, no iteration.
REQ-023 zero = (result == 0) for every opcode; cout and overflow SHALL be 0 for all ops except ADD/SUB; div_by_zero 0 except REQ-022.
REQ-024 in_valid while in_ready low SHALL be ignored; changes of a_in/b_in/op_in after accept SHALL NOT affect the result.
REQ-025 out_valid without out_ready SHALL hold indefinitely with no loss or change of data.

Reset
REQ-026 rst SHALL take priority over all other inputs, including mid-ITER and in DONE; operation in progress is discarded.
REQ-027 Reset values: state IDLE, out_valid 0, result 0, zero 0, cout 0, overflow 0, div_by_zero 0, iteration counter 0.
REQ-028 in_ready SHALL be 0 while rst is high and 1 in the first cycle after rst deasserts.

Structure
REQ-029 Shared package alu_pkg SHALL hold the opcode constants, FSM state encoding and WIDTH default.
REQ-030 Sub-module alu_iter_muldiv SHALL implement the iterative multiply/divide with start/done, product/quotient/remainder outputs.
REQ-031 Combinational ops 0-11 SHALL remain in alu_iter; one shared WIDTH+1 adder serves ADD/SUB/SLT/SLTU/EQU.

Verification
REQ-032 WIDTH=32, ADD 0x7FFFFFFF+1 -> result 0x80000000, overflow 1, cout 0, zero 0, out_valid 2 cycles after accept.
REQ-033 SUB 5-5 -> result 0, zero 1, cout 1; SLT 0x80000000 vs 1 -> 1; SLTU same operands -> 0.
REQ-034 MUL 0xFFFFFFFF*0xFFFFFFFF -> 0x00000001, MULHU -> 0xFFFFFFFE, out_valid exactly 33 cycles after accept.
REQ-035 DIVU 100/7 -> 14, REMU -> 2; DIVU 9/0 -> 0xFFFFFFFF, div_by_zero 1, latency 2 cycles.
REQ-036 out_ready held low 10 cycles in DONE -> result stable, in_ready 0; rst asserted mid-ITER -> out_valid 0, in_ready 1 the cycle after release.
REQ-037 Repeat REQ-032 to REQ-035 with WIDTH=8 (e.g. SRA 0x80 by 3 -> 0xF0, MUL latency 9 cycles).
